bram_write: RTL and testbench

- Write-side counterpart of the BRAM read block: receives a data stream from an upstream module, buffers it in a small FIFO, and writes it into a block RAM.
- Writes go to sequential addresses, repeated over a configured number of iterations. Each iteration restarts at the base address.
- Sits between a compute or forwarding stage (upstream, avail/valid handshake) and a BRAM write port (address / write-enable / data).

---
 rtl/bram_write_pkg.sv | 11 +
 rtl/bram_write_fifo.sv | 57 +++++
 rtl/bram_write.sv | 133 +++++++++++++
 tb/tb_bram_write.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bram_write_pkg.sv
// Shared definitions for BRAM read/write style blocks.
// FSM state encoding common to both directions.
package bram_write_pkg;

  typedef enum logic [1:0] {
    FSM_IDLE  = 2'd0,
    FSM_WRITE = 2'd1,
    FSM_DONE  = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/bram_write_fifo.sv
// Small circular FIFO buffering upstream words ahead of the BRAM port.
// Head word is visible combinationally on o_data.
module bram_write_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_SLOTS     = 4,
  parameter int LOG_NUM_SLOTS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_almost_full,
  output logic                  o_empty
);

  localparam int CW = LOG_NUM_SLOTS + 1;
  localparam logic [LOG_NUM_SLOTS-1:0] LAST = LOG_NUM_SLOTS'(NUM_SLOTS - 1);

  logic [DATA_WIDTH-1:0]    r_mem [NUM_SLOTS];
  logic [LOG_NUM_SLOTS-1:0] r_wr_ptr;
  logic [LOG_NUM_SLOTS-1:0] r_rd_ptr;
  logic [CW-1:0]            r_count;
  logic                     w_push;
  logic                     w_pop;

  assign o_full        = (r_count == CW'(NUM_SLOTS));
  assign o_almost_full = (r_count >= CW'(NUM_SLOTS - 1));
  assign o_empty       = (r_count == '0);
  assign o_data        = r_mem[r_rd_ptr];
  assign w_push        = i_push & ~o_full;
  assign w_pop         = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_push && w_pop)
        r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/bram_write.sv
// Streams upstream words into a BRAM at sequential addresses,
// repeating over a configured number of iterations.
module bram_write
  import bram_write_pkg::*;
#(
  parameter int DATA_WIDTH              = 8,
  parameter int LOG_MAX_ITERS           = 16,
  parameter int LOG_MAX_WRITES_PER_ITER = 16,
  parameter int LOG_MAX_ADDRESS         = 16,
  parameter int NUM_SLOTS               = 4,
  parameter int LOG_NUM_SLOTS           = 2,
  parameter     TYPE                    = "unspecified"
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               configure,
  input  logic [LOG_MAX_ITERS-1:0]           num_iters,
  input  logic [LOG_MAX_WRITES_PER_ITER-1:0] num_writes_per_iter,
  input  logic [LOG_MAX_ADDRESS-1:0]         base_address,
  input  logic                               valid_in,
  input  logic [DATA_WIDTH-1:0]              data_in,
  output logic                               avail_out,
  output logic [LOG_MAX_ADDRESS-1:0]         address_out,
  output logic                               write_out,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic                               done
);

  localparam int IW = LOG_MAX_ITERS;
  localparam int WW = LOG_MAX_WRITES_PER_ITER;
  localparam int AW = LOG_MAX_ADDRESS;

  fsm_state_t          r_state;
  fsm_state_t          w_next_state;
  logic [IW-1:0]       r_iters_left;
  logic [WW-1:0]       r_writes_left;
  logic [WW-1:0]       r_writes_cfg;
  logic [AW-1:0]       r_base;
  logic [AW-1:0]       r_addr;
  logic                w_full;
  logic                w_almost_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_wr;
  logic                w_last;
  logic                w_degen;
  logic [DATA_WIDTH-1:0] w_head;

  assign w_degen   = (num_iters == '0) | (num_writes_per_iter == '0);
  assign w_last    = (r_writes_left == WW'(1)) & (r_iters_left == IW'(1));
  assign avail_out = (r_state == FSM_WRITE) & ~w_almost_full;
  assign w_push    = valid_in & avail_out;
  assign w_wr      = (r_state == FSM_WRITE) & ~w_empty & ~configure;
  assign w_pop     = w_wr | ((r_state == FSM_DONE) & ~w_empty);

  bram_write_fifo #(
    .DATA_WIDTH    (DATA_WIDTH),
    .NUM_SLOTS     (NUM_SLOTS),
    .LOG_NUM_SLOTS (LOG_NUM_SLOTS)
  ) fifo_out (
    .clk           (clk),
    .rst           (rst),
    .i_push        (w_push),
    .i_data        (data_in),
    .i_pop         (w_pop),
    .o_data        (w_head),
    .o_full        (w_full),
    .o_almost_full (w_almost_full),
    .o_empty       (w_empty)
  );

  always_comb begin
    w_next_state = r_state;
    if (configure)
      w_next_state = w_degen ? FSM_DONE : FSM_WRITE;
    else if (w_wr && w_last)
      w_next_state = FSM_DONE;
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= FSM_IDLE;
    else      r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_iters_left  <= '0;
      r_writes_left <= '0;
      r_writes_cfg  <= '0;
      r_base        <= '0;
      r_addr        <= '0;
      write_out     <= 1'b0;
      address_out   <= '0;
      data_out      <= '0;
      done          <= 1'b0;
    end else begin
      write_out <= w_wr;
      done      <= (w_next_state == FSM_DONE);
      if (configure) begin
        r_iters_left  <= num_iters;
        r_writes_left <= num_writes_per_iter;
        r_writes_cfg  <= num_writes_per_iter;
        r_base        <= base_address;
        r_addr        <= base_address;
      end else if (w_wr) begin
        address_out <= r_addr;
        data_out    <= w_head;
        if (r_writes_left != WW'(1)) begin
          r_writes_left <= r_writes_left - 1'b1;
          r_addr        <= r_addr + 1'b1;
        end else if (r_iters_left != IW'(1)) begin
          r_iters_left  <= r_iters_left - 1'b1;
          r_writes_left <= r_writes_cfg;
          r_addr        <= r_base;
        end
      end
    end
  end

`ifdef DEBUG
  always_ff @(posedge clk) begin
    if (rst && configure)
      $display("[%s] configure iters=%0d writes=%0d base=%h",
               TYPE, num_iters, num_writes_per_iter, base_address);
    if (rst && w_wr)
      $display("[%s] write addr=%h data=%h", TYPE, r_addr, w_head);
    if (rst && w_pop && !w_wr)
      $display("[%s] discard data=%h", TYPE, w_head);
  end
`endif

endmodule

// File: tb/tb_bram_write.sv
// Directed bench for bram_write: basic, iterations, gaps,
// degenerate config, surplus/reconfigure and mid-run reset.
module tb_bram_write;

  logic        clk;
  logic        rst;
  logic        configure;
  logic [15:0] num_iters;
  logic [15:0] num_writes_per_iter;
  logic [15:0] base_address;
  logic        valid_in;
  logic [7:0]  data_in;
  logic        avail_out;
  logic [15:0] address_out;
  logic        write_out;
  logic [7:0]  data_out;
  logic        done;

  int checks   = 0;
  int failures = 0;

  bram_write #(.TYPE("tb")) dut (
    .clk                 (clk),
    .rst                 (rst),
    .configure           (configure),
    .num_iters           (num_iters),
    .num_writes_per_iter (num_writes_per_iter),
    .base_address        (base_address),
    .valid_in            (valid_in),
    .data_in             (data_in),
    .avail_out           (avail_out),
    .address_out         (address_out),
    .write_out           (write_out),
    .data_out            (data_out),
    .done                (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic exp_wr(input string tag, input logic w,
                        input logic [15:0] a, input logic [7:0] d,
                        input logic dn);
    chk({tag, ".write"}, 32'(write_out), 32'(w));
    if (w) begin
      chk({tag, ".addr"}, 32'(address_out), 32'(a));
      chk({tag, ".data"}, 32'(data_out), 32'(d));
    end
    chk({tag, ".done"}, 32'(done), 32'(dn));
  endtask

  task automatic cfg(input logic [15:0] it, input logic [15:0] wr,
                     input logic [15:0] b);
    configure = 1'b1;
    num_iters = it;
    num_writes_per_iter = wr;
    base_address = b;
    tick();
    configure = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    configure = 1'b0;
    num_iters = '0;
    num_writes_per_iter = '0;
    base_address = '0;
    valid_in = 1'b0;
    data_in = '0;
    tick();
    tick();
    chk("rst.write", 32'(write_out), 0);
    chk("rst.addr", 32'(address_out), 0);
    chk("rst.data", 32'(data_out), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.avail", 32'(avail_out), 0);
    rst = 1'b1;
    tick();
    chk("idle.avail", 32'(avail_out), 0);

    // basic: 1 x 4 at 0x10
    cfg(16'd1, 16'd4, 16'h10);
    chk("basic.avail", 32'(avail_out), 1);
    chk("basic.done0", 32'(done), 0);
    valid_in = 1'b1; data_in = 8'hA0; tick();
    exp_wr("basic.t0", 1'b0, 16'h0, 8'h0, 1'b0);
    data_in = 8'hA1; tick();
    exp_wr("basic.w0", 1'b1, 16'h10, 8'hA0, 1'b0);
    data_in = 8'hA2; tick();
    exp_wr("basic.w1", 1'b1, 16'h11, 8'hA1, 1'b0);
    data_in = 8'hA3; tick();
    exp_wr("basic.w2", 1'b1, 16'h12, 8'hA2, 1'b0);
    valid_in = 1'b0; tick();
    exp_wr("basic.w3", 1'b1, 16'h13, 8'hA3, 1'b1);
    chk("basic.avail_done", 32'(avail_out), 0);
    tick();
    exp_wr("basic.after", 1'b0, 16'h0, 8'h0, 1'b1);
    chk("basic.addr_hold", 32'(address_out), 32'h13);

    // iterations: 3 x 2 at 0x100
    cfg(16'd3, 16'd2, 16'h100);
    chk("iter.done_clr", 32'(done), 0);
    for (int k = 0; k < 7; k++) begin
      valid_in = (k < 6);
      data_in = 8'(k);
      tick();
      if (k == 0)
        exp_wr("iter.t0", 1'b0, 16'h0, 8'h0, 1'b0);
      else
        exp_wr($sformatf("iter.w%0d", k - 1), 1'b1,
               16'h100 + 16'((k - 1) % 2), 8'(k - 1), k == 6);
      if (k < 6) chk("iter.avail", 32'(avail_out), 1);
    end
    valid_in = 1'b0;

    // gaps; word offered while not writing is dropped
    valid_in = 1'b1; data_in = 8'hEE; tick();
    exp_wr("gap.pre", 1'b0, 16'h0, 8'h0, 1'b1);
    valid_in = 1'b0;
    cfg(16'd1, 16'd3, 16'h40);
    valid_in = 1'b1; data_in = 8'h01; tick();
    exp_wr("gap.t1", 1'b0, 16'h0, 8'h0, 1'b0);
    valid_in = 1'b0; tick();
    exp_wr("gap.t2", 1'b1, 16'h40, 8'h01, 1'b0);
    valid_in = 1'b1; data_in = 8'h02; tick();
    exp_wr("gap.t3", 1'b0, 16'h0, 8'h0, 1'b0);
    valid_in = 1'b0; tick();
    exp_wr("gap.t4", 1'b1, 16'h41, 8'h02, 1'b0);
    tick();
    exp_wr("gap.t5", 1'b0, 16'h0, 8'h0, 1'b0);
    valid_in = 1'b1; data_in = 8'h03; tick();
    exp_wr("gap.t6", 1'b0, 16'h0, 8'h0, 1'b0);
    valid_in = 1'b0; tick();
    exp_wr("gap.t7", 1'b1, 16'h42, 8'h03, 1'b1);

    // degenerate: zero writes per iteration
    cfg(16'd5, 16'd0, 16'h77);
    exp_wr("degen.c", 1'b0, 16'h0, 8'h0, 1'b1);
    chk("degen.avail", 32'(avail_out), 0);
    valid_in = 1'b1; data_in = 8'h99; tick();
    exp_wr("degen.t1", 1'b0, 16'h0, 8'h0, 1'b1);
    valid_in = 1'b0; tick();
    exp_wr("degen.t2", 1'b0, 16'h0, 8'h0, 1'b1);

    // surplus word discarded, then reconfigure
    cfg(16'd1, 16'd2, 16'h30);
    valid_in = 1'b1; data_in = 8'hB0; tick();
    exp_wr("surp.t1", 1'b0, 16'h0, 8'h0, 1'b0);
    data_in = 8'hB1; tick();
    exp_wr("surp.t2", 1'b1, 16'h30, 8'hB0, 1'b0);
    data_in = 8'hB2; tick();
    exp_wr("surp.t3", 1'b1, 16'h31, 8'hB1, 1'b1);
    valid_in = 1'b0; tick();
    exp_wr("surp.t4", 1'b0, 16'h0, 8'h0, 1'b1);
    chk("surp.hold", 32'(data_out), 32'hB1);
    tick();
    cfg(16'd1, 16'd1, 16'h20);
    chk("recfg.done", 32'(done), 0);
    valid_in = 1'b1; data_in = 8'h55; tick();
    exp_wr("recfg.t1", 1'b0, 16'h0, 8'h0, 1'b0);
    valid_in = 1'b0; tick();
    exp_wr("recfg.w", 1'b1, 16'h20, 8'h55, 1'b1);

    // reset mid-run with a word still buffered
    cfg(16'd1, 16'd8, 16'h0);
    for (int k = 1; k <= 4; k++) begin
      valid_in = 1'b1; data_in = 8'(k); tick();
      if (k > 1)
        exp_wr("mid.w", 1'b1, 16'(k - 2), 8'(k - 1), 1'b0);
    end
    valid_in = 1'b0; rst = 1'b0; tick();
    chk("mid.rst.write", 32'(write_out), 0);
    chk("mid.rst.addr", 32'(address_out), 0);
    chk("mid.rst.data", 32'(data_out), 0);
    chk("mid.rst.done", 32'(done), 0);
    chk("mid.rst.avail", 32'(avail_out), 0);
    rst = 1'b1; tick();
    exp_wr("mid.idle", 1'b0, 16'h0, 8'h0, 1'b0);
    cfg(16'd1, 16'd1, 16'h60);
    tick();
    exp_wr("mid.nostale1", 1'b0, 16'h0, 8'h0, 1'b0);
    chk("mid.avail", 32'(avail_out), 1);
    valid_in = 1'b1; data_in = 8'h66; tick();
    exp_wr("mid.nostale2", 1'b0, 16'h0, 8'h0, 1'b0);
    valid_in = 1'b0; tick();
    exp_wr("mid.w66", 1'b1, 16'h60, 8'h66, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
